// File: rtl/seq_pkg.sv
// Shared definitions for the LFSR sequence player (Simon-style game core).
//   state_e  : FSM state encoding (7 states)
//   SYM_W    : width of one stored symbol / button code
//   NUM_SYMS : number of distinct symbols (one LED / button each)
package seq_pkg;

    localparam int SYM_W    = 2;
    localparam int NUM_SYMS = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_APPEND   = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_PASS     = 3'd5,
        ST_FAIL     = 3'd6
    } state_e;

endpackage

// File: rtl/seq_mem.sv
// Symbol store for the sequence player: DEPTH x SYM_W register file.
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : symbol to store
//   raddr : read address
//   rdata : symbol at raddr (asynchronous read)
// Contents are not reset; entries are only read after being written.
module seq_mem
    import seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SYM_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [SYM_W-1:0]  rdata
);

    // All entries flattened so the read port is a single indexed slice.
    logic [DEPTH*SYM_W-1:0] flat;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [SYM_W-1:0] entry_q;

        always_ff @(posedge clk) begin
            if (we && (waddr == ADDR_W'(gi))) begin
                entry_q <= wdata;
            end
        end

        assign flat[gi*SYM_W +: SYM_W] = entry_q;
    end

    assign rdata = flat[raddr*SYM_W +: SYM_W];

endmodule

// File: rtl/lfsr_seq_player.sv
// Simon-style game core fed by a 7-bit LFSR.
// Each round appends lfsr_value[1:0] to the stored sequence (pulsing lfsr_en so the
// LFSR advances), replays the sequence on four one-hot LEDs, then checks button input.
//   clk, rst_n   : clock, synchronous active-low reset
//   lfsr_value   : LFSR state, bits [1:0] sampled in APPEND only
//   lfsr_en      : one-cycle advance pulse for the LFSR
//   round_start  : begin next round (honoured in IDLE only)
//   btn_valid    : button strobe (honoured in WAIT_IN only), btn_code = button index
//   led_onehot   : replay display
//   seq_len      : symbols stored
//   busy, await_input, round_pass, round_fail, full : status, decoded from registers
module lfsr_seq_player
    import seq_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          lfsr_value,
    output logic                lfsr_en,
    input  logic                round_start,
    input  logic                btn_valid,
    input  logic [SYM_W-1:0]    btn_code,
    output logic [NUM_SYMS-1:0] led_onehot,
    output logic [LEN_W-1:0]    seq_len,
    output logic                busy,
    output logic                await_input,
    output logic                round_pass,
    output logic                round_fail,
    output logic                full
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W = $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) + 1);

    // Timer holds "cycles remaining after this one", so it loads N-1.
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

    state_e            state_q,   state_d;
    logic [LEN_W-1:0]  seq_len_q, seq_len_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [TMR_W-1:0]  timer_q,   timer_d;

    logic              mem_we;
    logic [SYM_W-1:0]  cur_sym;
    logic              is_last;
    logic              is_full;

    // Upper LFSR bits are intentionally not consumed.
    logic              unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_value[6:2];

    seq_mem #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (IDX_W)
    ) u_seq_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (seq_len_q[IDX_W-1:0]),
        .wdata (lfsr_value[SYM_W-1:0]),
        .raddr (idx_q),
        .rdata (cur_sym)
    );

    // seq_len is >= 1 whenever is_last is consulted (SHOW_OFF / WAIT_IN).
    assign is_last = (LEN_W'(idx_q) == (seq_len_q - LEN_W'(1)));
    assign is_full = (seq_len_q == LEN_W'(MAX_LEN));

    always_comb begin
        state_d   = state_q;
        seq_len_d = seq_len_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (round_start) begin
                    idx_d = '0;
                    if (is_full) begin
                        // Sequence already at capacity: replay without appending.
                        state_d = ST_SHOW_ON;
                        timer_d = ON_LOAD;
                    end else begin
                        state_d = ST_APPEND;
                        timer_d = '0;
                    end
                end
            end

            ST_APPEND: begin
                mem_we    = 1'b1;
                seq_len_d = seq_len_q + LEN_W'(1);
                idx_d     = '0;
                timer_d   = ON_LOAD;
                state_d   = ST_SHOW_ON;
            end

            ST_SHOW_ON: begin
                if (timer_q == '0) begin
                    state_d = ST_SHOW_OFF;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_SHOW_OFF: begin
                if (timer_q == '0) begin
                    if (is_last) begin
                        state_d = ST_WAIT_IN;
                        idx_d   = '0;
                        timer_d = '0;
                    end else begin
                        state_d = ST_SHOW_ON;
                        idx_d   = idx_q + IDX_W'(1);
                        timer_d = ON_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_WAIT_IN: begin
                if (btn_valid) begin
                    if (btn_code != cur_sym) begin
                        state_d = ST_FAIL;
                    end else if (is_last) begin
                        state_d = ST_PASS;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_PASS: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end

            ST_FAIL: begin
                seq_len_d = '0;
                state_d   = ST_IDLE;
                timer_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            seq_len_q <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            seq_len_q <= seq_len_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
        end
    end

    // Outputs depend only on registered state and stored symbols.
    assign lfsr_en     = (state_q == ST_APPEND);
    assign busy        = (state_q != ST_IDLE);
    assign await_input = (state_q == ST_WAIT_IN);
    assign round_pass  = (state_q == ST_PASS);
    assign round_fail  = (state_q == ST_FAIL);
    assign full        = is_full;
    assign seq_len     = seq_len_q;

    for (genvar gi = 0; gi < NUM_SYMS; gi++) begin : g_led
        assign led_onehot[gi] = (state_q == ST_SHOW_ON) && (cur_sym == SYM_W'(gi));
    end

endmodule
